// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider. Each channel has a programmable divisor, a glitch-free enable and a tick strobe.
// Optional macro CLK_DIV_SYNC_EN adds the SyncIn port, which realigns all running channels.
module clk_div_multi #(
  parameter int  NUM_CH  = 2,
  parameter int  DIV_W   = 8,
  parameter int  DEF_DIV = 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ClkIn,
  input  logic              nRst,
  input  logic [NUM_CH-1:0] Enable,
  input  logic              DivWe,
  input  logic [CH_W-1:0]   DivCh,
  input  logic [DIV_W-1:0]  DivVal,
`ifdef CLK_DIV_SYNC_EN
  input  logic              SyncIn,
`endif
  output logic [NUM_CH-1:0] ClkOut,
  output logic [NUM_CH-1:0] TickOut,
  output logic [NUM_CH-1:0] Pending
);

  // state    | meaning
  // ST_IDLE  | counter parked at div-1, output low, waiting for Enable
  // ST_RUN   | generating periods continuously
  // ST_STOP  | Enable dropped; finishing the current period before parking
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
  localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEF_DIV);

  logic             w_sync;
  logic [DIV_W-1:0] w_wr_val;

`ifdef CLK_DIV_SYNC_EN
  assign w_sync = SyncIn;
`else
  assign w_sync = 1'b0;
`endif

  // Divisors below 2 cannot form a period with both a high and a low phase.
  assign w_wr_val = (DivVal < TWO) ? TWO : DivVal;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;
    logic             w_wr;
    logic             w_active;
    logic             w_wrap;
    logic             w_apply;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W:0]   w_half;

    assign w_wr      = DivWe && (DivCh == CH_W'(g));
    assign w_active  = (r_state != ST_IDLE);
    assign w_wrap    = (r_cnt == r_div - ONE);
    // A new divisor only lands at a period boundary, so a period is never truncated.
    assign w_apply   = r_pend && (!w_active || w_wrap || w_sync);
    assign w_div_nxt = w_apply ? r_shadow : r_div;
    assign w_half    = ({1'b0, w_div_nxt} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = w_div_nxt - ONE;
          if (Enable[g]) w_state_nxt = ST_RUN;
        end
        default: begin
          if (w_sync) begin
            w_cnt_nxt   = '0;
            w_state_nxt = Enable[g] ? ST_RUN : ST_STOP;
          end else if (w_wrap && !Enable[g]) begin
            w_cnt_nxt   = w_div_nxt - ONE;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt   = w_wrap ? '0 : r_cnt + ONE;
            w_state_nxt = Enable[g] ? ST_RUN : ST_STOP;
          end
        end
      endcase
    end

    always_ff @(posedge ClkIn or negedge nRst) begin
      if (!nRst) begin
        r_state  <= ST_IDLE;
        r_cnt    <= DEF_D - ONE;
        r_div    <= DEF_D;
        r_shadow <= DEF_D;
        r_pend   <= 1'b0;
        r_clk    <= 1'b0;
        r_tick   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_div   <= w_div_nxt;
        r_clk   <= ({1'b0, w_cnt_nxt} < w_half);
        r_tick  <= (w_state_nxt != ST_IDLE) && (w_cnt_nxt == '0);
        // A same-edge write wins over apply: the fresh value waits for the next boundary.
        if (w_wr) begin
          r_shadow <= w_wr_val;
          r_pend   <= 1'b1;
        end else if (w_apply) begin
          r_pend   <= 1'b0;
        end
      end
    end

    assign ClkOut[g]  = r_clk;
    assign TickOut[g] = r_tick;
    assign Pending[g] = r_pend;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios then random traffic, checked every cycle against a period-level model.
module tb_clk_div_multi;
  localparam int NUM_CH  = 3;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 2;
  localparam int CH_W    = 2;

  logic              ClkIn = 1'b0;
  logic              nRst = 1'b1;
  logic [NUM_CH-1:0] Enable = '0;
  logic              DivWe = 1'b0;
  logic [CH_W-1:0]   DivCh = '0;
  logic [DIV_W-1:0]  DivVal = '0;
  logic              SyncIn = 1'b0;
  logic [NUM_CH-1:0] ClkOut;
  logic [NUM_CH-1:0] TickOut;
  logic [NUM_CH-1:0] Pending;

  int vectors = 0;
  int miscompares = 0;

  // Model: each channel is either parked or busy inside a period at position m_pos.
  int m_pos    [NUM_CH];
  int m_div    [NUM_CH];
  int m_shadow [NUM_CH];
  bit m_busy   [NUM_CH];
  bit m_pend   [NUM_CH];

  clk_div_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .ClkIn  (ClkIn),
    .nRst   (nRst),
    .Enable (Enable),
    .DivWe  (DivWe),
    .DivCh  (DivCh),
    .DivVal (DivVal),
`ifdef CLK_DIV_SYNC_EN
    .SyncIn (SyncIn),
`endif
    .ClkOut (ClkOut),
    .TickOut(TickOut),
    .Pending(Pending)
  );

  always #5 ClkIn = ~ClkIn;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c] = DEF_DIV; m_shadow[c] = DEF_DIV; m_pos[c] = DEF_DIV - 1;
      m_busy[c] = 1'b0;   m_pend[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit sync, en, at_end, apply;
    int nd;
`ifdef CLK_DIV_SYNC_EN
    sync = SyncIn;
`else
    sync = 1'b0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      en     = Enable[c];
      at_end = m_busy[c] && (m_pos[c] == m_div[c] - 1);
      apply  = m_pend[c] && (!m_busy[c] || at_end || sync);
      nd     = apply ? m_shadow[c] : m_div[c];
      if (!m_busy[c]) begin
        m_pos[c]  = nd - 1;
        m_busy[c] = en;
      end else if (sync) begin
        m_pos[c] = 0;
      end else if (at_end) begin
        if (en) m_pos[c] = 0;
        else begin m_busy[c] = 1'b0; m_pos[c] = nd - 1; end
      end else begin
        m_pos[c] = m_pos[c] + 1;
      end
      m_div[c] = nd;
      if (DivWe && int'(DivCh) == c) begin
        m_shadow[c] = (int'(DivVal) < 2) ? 2 : int'(DivVal);
        m_pend[c]   = 1'b1;
      end else if (apply) begin
        m_pend[c] = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [NUM_CH-1:0] ec, et, ep;
    for (int c = 0; c < NUM_CH; c++) begin
      ec[c] = m_busy[c] && (m_pos[c] < (m_div[c] + 1) / 2);
      et[c] = m_busy[c] && (m_pos[c] == 0);
      ep[c] = m_pend[c];
    end
    vectors++;
    assert (ClkOut === ec && TickOut === et && Pending === ep) else begin
      miscompares++;
      $error("FAIL %s @%0t: clk/tick/pend got %b/%b/%b want %b/%b/%b",
             tag, $time, ClkOut, TickOut, Pending, ec, et, ep);
    end
  endtask

  task automatic check_const(input string tag, input logic [NUM_CH-1:0] got,
                             input logic [NUM_CH-1:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s @%0t: got %b want %b", tag, $time, got, want);
    end
  endtask

  task automatic step(input string tag);
    @(posedge ClkIn);
    model_step();
    #1;
    check(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic write_div(input int ch, input int val, input string tag);
    DivWe = 1'b1; DivCh = CH_W'(ch); DivVal = DIV_W'(val);
    step(tag);
    DivWe = 1'b0;
  endtask

  task automatic mid_reset(input string tag);
    #2 nRst = 1'b0;
    #1;
    model_reset();
    check_const({tag, "_clk"}, ClkOut, '0);
    check_const({tag, "_tick"}, TickOut, '0);
    check_const({tag, "_pend"}, Pending, '0);
    #1 nRst = 1'b1;
  endtask

  initial begin
    bit found;
    #1 nRst = 1'b0;
    #5;
    model_reset();
    check_const("reset_clk", ClkOut, '0);
    check_const("reset_pend", Pending, '0);
    #6 nRst = 1'b1;

    // Default /2 on all channels: first rise one edge after Enable is seen.
    Enable = '1;
    step("start1");
    check_const("start1_clk", ClkOut, '0);
    step("start2");
    check_const("start2_clk", ClkOut, '1);
    check_const("start2_tick", TickOut, '1);
    run("div2", 6);

    write_div(1, 4, "wr4");
    check_const("wr4_pend", Pending, 3'b010);
    run("div4", 12);

    write_div(0, 5, "wr5");
    run("div5", 15);
    write_div(0, 0, "wr0");
    run("div0", 8);
    write_div(3, 7, "wr_bad_ch");
    check_const("bad_ch_pend", Pending, '0);
    run("bad_ch", 4);

    // Same-channel writes back to back, plus a write landing on a boundary.
    write_div(2, 6, "b2b_a");
    write_div(2, 3, "b2b_b");
    run("b2b", 10);

    // Div 8 on ch0, drop Enable just after a rise: period must complete, then hold low.
    write_div(0, 8, "wr8");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step("wait_rise");
      if (TickOut[0] && m_div[0] == 8) found = 1'b1;
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL wait_rise: got no ch0 tick at div 8 want one within 40 cycles");
    end
    step("drop");
    Enable[0] = 1'b0;
    run("stopping", 12);
    check_const("stopped_clk", ClkOut & 3'b001, '0);
    Enable[0] = 1'b1;
    step("reen1");
    check_const("reen1_clk", ClkOut & 3'b001, '0);
    step("reen2");
    check_const("reen2_tick", TickOut & 3'b001, 3'b001);

    // Async reset while a write is pending.
    write_div(1, 9, "wr9");
    mid_reset("rst_mid");
    Enable = '1;
    run("post_rst", 8);

`ifdef CLK_DIV_SYNC_EN
    write_div(0, 2, "sync_w0");
    write_div(1, 6, "sync_w1");
    run("sync_pre", 15);
    SyncIn = 1'b1;
    step("sync");
    SyncIn = 1'b0;
    check_const("sync_tick", TickOut & 3'b011, 3'b011);
    run("sync_post", 14);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) Enable[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        DivWe  = 1'b1;
        DivCh  = CH_W'($urandom_range(0, 3));
        DivVal = ($urandom_range(0, 7) == 0) ? DIV_W'($urandom_range(0, 255))
                                              : DIV_W'($urandom_range(0, 12));
      end else begin
        DivWe = 1'b0;
      end
`ifdef CLK_DIV_SYNC_EN
      SyncIn = ($urandom_range(0, 30) == 0);
`endif
      step("rand");
      if ($urandom_range(0, 499) == 0) mid_reset("rand_rst");
    end
    DivWe = 1'b0;
    SyncIn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
